// File: rtl/inst_mem_loader.sv
// Instruction memory loader: turns a byte stream carrying a length-prefixed
// program image into 32-bit word writes, and keeps the CPU held until a
// complete, valid image has been written.
module inst_mem_loader #(
  parameter int MAX_WORDS = 201,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_HI  = 3'd1,
    HDR_LO  = 3'd2,
    DATA    = 3'd3,
    DONE_ST = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

  state_t           state;
  logic [7:0]       hdr_hi;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  // Only the three oldest bytes need storing; the fourth arrives on in_data.
  logic [23:0]      shift;

  logic             accept;
  logic [CNT_W-1:0] hdr_n;
  logic             last_word;

  assign accept    = in_valid & in_ready;
  assign hdr_n     = CNT_W'({hdr_hi, in_data});
  assign last_word = ((word_idx + CNT_W'(1)) == n_words);

  // Loader FSM with all outputs registered; write strobe and done are one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_hold <= 1'b1;
      hdr_hi   <= '0;
      n_words  <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      shift    <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE, DONE_ST, ERR: begin
          if (start) begin
            state    <= HDR_HI;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            error    <= 1'b0;
            word_idx <= '0;
            byte_cnt <= '0;
            shift    <= '0;
          end
        end
        HDR_HI: begin
          if (accept) begin
            hdr_hi <= in_data;
            state  <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            n_words <= hdr_n;
            if ((hdr_n == '0) || (hdr_n > MAX_N)) begin
              // Empty or oversized image: park in ERR with the CPU still held.
              state    <= ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            shift    <= {shift[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_en    <= 1'b1;
              wr_data  <= {shift, in_data};
              wr_addr  <= {{(30-CNT_W){1'b0}}, word_idx, 2'b00};
              word_idx <= word_idx + CNT_W'(1);
              if (last_word) begin
                // Final word: completion is signalled alongside its write.
                state    <= DONE_ST;
                done     <= 1'b1;
                busy     <= 1'b0;
                cpu_hold <= 1'b0;
                in_ready <= 1'b0;
              end
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: directed sequence of loads driven from word lists,
// with expected writes derived from the image contents.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] img[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          done_cnt;
  logic [31:0] done_addr;

  inst_mem_loader #(.MAX_WORDS(201), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  // Collect every write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
    end
    if (done) begin
      done_cnt++;
      done_addr = wr_en ? wr_addr : 32'hFFFF_FFFF;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running / expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte (called at a negedge), then hold in_valid low for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check1("in_ready_before_byte", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic int pick_gap(input int gap);
    return (gap < 0) ? int'($urandom_range(0, 3)) : gap;
  endfunction

  // Load img with header = its length; gap<0 means random gaps.
  task automatic run_load(input int gap, input bit mid_start);
    int n;
    int k;
    logic [31:0] w;
    n = img.size();
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    done_addr = 32'hDEAD_BEEF;
    pulse_start();
    send_byte(8'(n >> 8), pick_gap(gap));
    send_byte(8'(n), pick_gap(gap));
    k = 0;
    foreach (img[i]) begin
      w = img[i];
      for (int j = 3; j >= 0; j--) begin
        send_byte(w[j*8 +: 8], pick_gap(gap));
        k++;
        if (mid_start && k == 5) pulse_start();
      end
    end
    repeat (3) @(negedge clk);
    check("write_count", 32'(got_addr.size()), 32'(n));
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), got_addr[i], 32'(i * 4));
      check($sformatf("wr_data[%0d]", i), got_data[i], img[i]);
    end
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_with_last_write", done_addr, 32'((n - 1) * 4));
    check1("cpu_hold_after_load", cpu_hold, 1'b0);
    check1("busy_after_load", busy, 1'b0);
    check1("error_after_load", error, 1'b0);
    check1("in_ready_after_load", in_ready, 1'b0);
  endtask

  task automatic run_bad_hdr(input logic [7:0] hi, input logic [7:0] lo);
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    pulse_start();
    check1("busy_in_header", busy, 1'b1);
    send_byte(hi, 0);
    send_byte(lo, 0);
    repeat (3) @(negedge clk);
    check1("error_bad_hdr", error, 1'b1);
    check1("in_ready_bad_hdr", in_ready, 1'b0);
    check1("cpu_hold_bad_hdr", cpu_hold, 1'b1);
    check1("busy_bad_hdr", busy, 1'b0);
    check("writes_bad_hdr", 32'(got_addr.size()), 32'd0);
    check("done_bad_hdr", 32'(done_cnt), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check1({tag, "_in_ready"}, in_ready, 1'b0);
    check1({tag, "_wr_en"}, wr_en, 1'b0);
    check({tag, "_wr_addr"}, wr_addr, 32'h0);
    check({tag, "_wr_data"}, wr_data, 32'h0);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_done"}, done, 1'b0);
    check1({tag, "_error"}, error, 1'b0);
    check1({tag, "_cpu_hold"}, cpu_hold, 1'b1);
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1 check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal two-word load, in_valid held high.
    img = '{32'h8001_060A, 32'h0401_1000};
    run_load(0, 1'b0);

    // Same image with 3-cycle gaps between bytes.
    run_load(3, 1'b0);

    // Bad headers, then recovery.
    run_bad_hdr(8'h00, 8'h00);
    run_bad_hdr(8'h00, 8'hCA);
    img.delete();
    for (int i = 0; i < 3; i++) img.push_back($urandom);
    run_load(-1, 1'b0);

    // Largest image with random contents and random gaps.
    img.delete();
    for (int i = 0; i < 201; i++) img.push_back($urandom);
    run_load(-1, 1'b0);

    // start pulsed mid-DATA must be ignored.
    img.delete();
    for (int i = 0; i < 4; i++) img.push_back($urandom);
    run_load(0, 1'b1);

    // Reset mid-load after two data bytes.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #1 rst = 1'b1;
    #1 check_reset_values("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    img.delete();
    for (int i = 0; i < 2; i++) img.push_back($urandom);
    run_load(-1, 1'b0);

    // A few more random-length loads.
    for (int r = 0; r < 4; r++) begin
      img.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) img.push_back($urandom);
      run_load(-1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction memory. Receives a program image as a byte stream (for example from a UART receiver or a debug port).
- Assembles the bytes into 32-bit instruction words and drives a write port into a writable instruction memory. Addressing is byte-based: the memory indexes by addr>>2.
- Holds the CPU in reset/stall (cpu_hold) until a complete, valid image has been written.

Parameters:
- MAX_WORDS, 201, instruction memory depth in words (indices 0..MAX_WORDS-1).
- CNT_W, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; sampled only in IDLE, DONE_ST or ERR.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  32  byte address of the word (word_index*4).
- wr_data  output  32  assembled instruction word.
- busy  output  1  a load is in progress.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky bad-header flag; cleared by start or rst.
- cpu_hold  output  1  keeps the pipeline stalled; high from reset until the first successful load.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, cpu_hold=1; byte counter, word counter and shift register all cleared. A reset asserted mid-load abandons the load. Words already written stay in memory, but cpu_hold remains 1.
- Byte handshake: a byte is consumed on any rising edge where in_valid & in_ready. in_ready is a registered output: 1 in HDR_HI, HDR_LO and DATA; 0 elsewhere. The loader never back-pressures inside these states. in_valid gaps of any length are allowed.
- Image format:
  - 2-byte word count N, most significant byte first.
  - Then N*4 bytes. Each word is sent MSB first, i.e. bytes [31:24],[23:16],[15:8],[7:0].
- State IDLE / DONE_ST / ERR, on start:
  - go to HDR_HI; busy=1, cpu_hold=1, error=0.
  - clear the word index and the byte counter.
- HDR_HI: capture N[15:8]; go to HDR_LO.
- HDR_LO:
  - capture N[7:0].
  - if the full N==0 or N>MAX_WORDS: go to ERR (error=1, busy=0, cpu_hold stays 1).
  - otherwise go to DATA.
- DATA:
  - each accepted byte shifts into a 32-bit register: reg = {reg[23:0], in_data}. A 2-bit byte counter increments and wraps 3->0.
  - on acceptance of the 4th byte (counter==3), on the next cycle: wr_en=1 for exactly one cycle, wr_data = assembled word, wr_addr = word_index<<2. word_index then increments.
  - a byte may be accepted in the same cycle wr_en is high; the write path is one cycle and does not stall.
- Completion:
  - when the 4th byte of word N-1 is accepted, go to DONE_ST.
  - in the cycle of that final wr_en: done=1 (exactly one cycle), busy=0, cpu_hold=0, in_ready=0.
- DONE_ST: idle, with cpu_hold=0. A new start re-enters HDR_HI and sets cpu_hold=1.
- ERR: in_ready=0. The error flag holds until start or rst; start is accepted from ERR.
- start while busy (HDR_HI/HDR_LO/DATA) is ignored.
- wr_addr and wr_data hold their last values when wr_en=0.
- Latency: 1 cycle from acceptance of a word's last byte to its wr_en.
- Maximum image size: N=MAX_WORDS, last write to wr_addr=(MAX_WORDS-1)*4 (800 by default).

Test Plan:
- Reset: assert rst with no clock edge -> all outputs take their reset values immediately; cpu_hold=1, in_ready=0.
- Nominal load: start, then bytes 00 02 80 01 06 0A 04 01 10 00 with in_valid held high.
  - wr_en pulse 1: addr 0x0, data 0x8001060A.
  - wr_en pulse 2: addr 0x4, data 0x04011000.
  - done pulses with the second write; cpu_hold falls to 0; busy drops to 0.
- Gapped stream: same image with in_valid low for 3 cycles between every byte -> identical two writes, no extra wr_en, done exactly once.
- Bad header:
  - header 00 00 -> ERR, error=1, in_ready=0, no wr_en, cpu_hold=1.
  - then start with header 00 CA (202) -> error set again.
  - a later valid load clears error.
- Boundary and abort:
  - N=201 (00 C9) -> final write at addr 800; done once.
  - start pulsed mid-DATA -> ignored.
  - rst asserted after 2 data bytes -> immediate reset values. The next load writes its first word at addr 0 with correct data, proving no stale bytes carried over.
